eth_rx_sched: RTL

- Buffer scheduler between the Ethernet RX capture writer, the frame parser and the payload consumer.
- Owns NBUF packet RAM banks and moves each bank through a fixed lifecycle: allocate to capture, queue, run parser, hand payload to consumer, release.
- Starts the parser with a one-cycle newpacket pulse. Retires the bank on the parser's start_read/last_addr completion, or drops it on watchdog timeout, because the parser returns to idle silently on non-IP/non-UDP frames.

---
 rtl/eth_rx_sched.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_sched.sv
// eth_rx_sched: packet RAM bank scheduler between the RX capture writer,
// the frame parser and the payload consumer.
//
// Each bank moves FREE -> CAPT -> FILLED -> PARSE -> PAYLD -> FREE. A parse
// ends either on par_ok or on a watchdog timeout, because the parser goes
// back to idle without any notification on non-IP/non-UDP frames.
//
// Handshakes: all inputs (cap_done, par_ok, pay_ack) are single-cycle
// pulses sampled on the rising clock edge. Each is acted on only when the
// matching ownership flag (cap_rdy, par_busy, pay_valid) is high in that
// cycle. All outputs are registered.
module eth_rx_sched #(
    parameter int NBUF    = 2,
    parameter int BANK_W  = (NBUF > 2) ? $clog2(NBUF) : 1,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              cap_rdy,
    output logic [BANK_W-1:0] cap_bank,
    input  logic              cap_done,
    output logic              newpacket,
    output logic [BANK_W-1:0] par_bank,
    output logic              par_busy,
    input  logic              par_ok,
    input  logic [ADDR_W-1:0] par_last_addr,
    output logic              pay_valid,
    output logic [BANK_W-1:0] pay_bank,
    output logic [ADDR_W-1:0] pay_last_addr,
    input  logic              pay_ack,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  ovf_cnt
);

    localparam int TMR_W = $clog2(TIMEOUT) + 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [BANK_W-1:0] PTR_LAST = BANK_W'(NBUF - 1);

    typedef enum logic [2:0] {B_FREE, B_CAPT, B_FILLED, B_PARSE, B_PAYLD} bank_st_t;
    typedef enum logic {P_IDLE, P_RUN} p_state_t;

    bank_st_t          bank_st [NBUF];
    p_state_t          p_state, p_next;
    logic [TMR_W-1:0]  timer;

    logic [BANK_W-1:0] q_mem [NBUF];
    logic [BANK_W-1:0] q_wr, q_rd;
    logic [BANK_W:0]   q_cnt;
    logic [BANK_W-1:0] q_head;

    logic              any_free;
    logic [BANK_W-1:0] free_idx;
    logic              alloc, cap_push, cap_ovf, pay_rel;
    logic              launch, par_hit, par_exp;

    function automatic logic [BANK_W-1:0] ptr_inc(input logic [BANK_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign q_head   = q_mem[q_rd];
    assign par_busy = (p_state == P_RUN);
    assign alloc    = !cap_rdy && any_free;
    assign cap_push = cap_done && cap_rdy;
    assign cap_ovf  = cap_done && !cap_rdy;
    assign pay_rel  = pay_ack && pay_valid;

    // Lowest-index FREE bank for the next capture allocation
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = NBUF - 1; i >= 0; i--) begin
            if (bank_st[i] == B_FREE) begin
                any_free = 1'b1;
                free_idx = BANK_W'(i);
            end
        end
    end

    // Parser FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) p_state <= P_IDLE;
        else     p_state <= p_next;
    end

    // Parser FSM next state
    always_comb begin
        p_next = p_state;
        case (p_state)
            P_IDLE: if (launch) p_next = P_RUN;
            P_RUN:  if (par_hit || par_exp) p_next = P_IDLE;
            default: p_next = P_IDLE;
        endcase
    end

    // Parser FSM decodes: launch only with nothing in PARSE or PAYLD; par_ok beats expiry
    always_comb begin
        launch  = (p_state == P_IDLE) && (q_cnt != '0) && !pay_valid;
        par_hit = (p_state == P_RUN) && par_ok;
        par_exp = (p_state == P_RUN) && !par_ok && (timer == TMR_LAST);
    end

    // Parser start pulse, bank select and watchdog timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            newpacket <= 1'b0;
            par_bank  <= '0;
            timer     <= '0;
        end else begin
            newpacket <= launch;
            if (launch) begin
                par_bank <= q_head;
                timer    <= '0;
            end else if (p_state == P_RUN) begin
                timer    <= timer + 1'b1;
            end
        end
    end

    // Capture bank offer: re-allocate only once the previous offer is gone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_rdy  <= 1'b0;
            cap_bank <= '0;
        end else if (alloc) begin
            cap_rdy  <= 1'b1;
            cap_bank <= free_idx;
        end else if (cap_push) begin
            cap_rdy  <= 1'b0;
        end
    end

    // Per-bank lifecycle; concurrent events always target different banks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NBUF; i++) bank_st[i] <= B_FREE;
        end else begin
            if (alloc)    bank_st[free_idx] <= B_CAPT;
            if (cap_push) bank_st[cap_bank] <= B_FILLED;
            if (launch)   bank_st[q_head]   <= B_PARSE;
            if (par_hit)  bank_st[par_bank] <= B_PAYLD;
            if (par_exp)  bank_st[par_bank] <= B_FREE;
            if (pay_rel)  bank_st[pay_bank] <= B_FREE;
        end
    end

    // Fill queue pointers and occupancy (never overflows: one entry per bank)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_wr  <= '0;
            q_rd  <= '0;
            q_cnt <= '0;
        end else begin
            if (cap_push) q_wr <= ptr_inc(q_wr);
            if (launch)   q_rd <= ptr_inc(q_rd);
            case ({cap_push, launch})
                2'b10:   q_cnt <= q_cnt + 1'b1;
                2'b01:   q_cnt <= q_cnt - 1'b1;
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    // Fill queue storage
    always_ff @(posedge clk) begin
        if (cap_push) q_mem[q_wr] <= cap_bank;
    end

    // Payload hand-off to the consumer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pay_valid     <= 1'b0;
            pay_bank      <= '0;
            pay_last_addr <= '0;
        end else begin
            if (par_hit) begin
                pay_valid     <= 1'b1;
                pay_bank      <= par_bank;
                pay_last_addr <= par_last_addr;
            end else if (pay_rel) begin
                pay_valid     <= 1'b0;
            end
        end
    end

    // Saturating status counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
            ovf_cnt  <= '0;
        end else begin
            if (pay_rel && (pkt_cnt  != '1)) pkt_cnt  <= pkt_cnt  + 1'b1;
            if (par_exp && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
            if (cap_ovf && (ovf_cnt  != '1)) ovf_cnt  <= ovf_cnt  + 1'b1;
        end
    end

endmodule
